// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   uart_state_e  : frame FSM states (IDLE, START, DATA, STOP)
//   NBIT_DATA_DEF : default number of data bits per frame
//   NUM_TICKS_DEF : default number of oversampling ticks per bit period
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int NBIT_DATA_DEF = 8;
  localparam int NUM_TICKS_DEF = 16;

endpackage

// File: rtl/uart_tx_buf_if.sv
// uart_tx_buf_if: byte handshake into the buffered UART transmitter.
//   data_in    : byte to send (producer -> transmitter)
//   data_valid : data_in valid (producer -> transmitter)
//   data_ready : transmitter can accept; transfer when valid && ready
// Modports: master = producer side, slave = transmitter side.
interface uart_tx_buf_if
  import uart_pkg::*;
#(
  parameter int NBIT_DATA = NBIT_DATA_DEF
) ();

  logic [NBIT_DATA-1:0] data_in;
  logic                 data_valid;
  logic                 data_ready;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready
  );

endinterface

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous single-clock FIFO.
//   clk   : clock, rising edge
//   reset : synchronous active-low reset (pointers and count only)
//   push  : write din (ignored when full)
//   pop   : discard the oldest entry (ignored when empty)
//   din   : write data
//   dout  : oldest entry, valid while !empty
//   count : entries held
//   full  : count == DEPTH
//   empty : count == 0
// DEPTH must be a power of two so the pointers wrap naturally.
module uart_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage carries no reset; only the pointers and count define contents.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buf.sv
// uart_tx_buf: buffered 8N1 UART transmitter.
//   CLK          : system clock, rising edge
//   reset        : synchronous active-low reset
//   tick         : one-cycle baud oversampling enable
//   in_if        : byte handshake (data_in / data_valid / data_ready)
//   tx_bit       : registered serial line, idle high
//   tx_busy      : high while a frame is in START/DATA/STOP
//   tx_done_tick : one-cycle pulse as the FSM returns to IDLE after a stop bit
//   fifo_count   : entries waiting in the FIFO
// Bytes are queued in uart_fifo and sent LSB first, NUM_TICKS ticks per bit.
module uart_tx_buf
  import uart_pkg::*;
#(
  parameter int NBIT_DATA  = NBIT_DATA_DEF,
  parameter int NUM_TICKS  = NUM_TICKS_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        CLK,
  input  logic                        reset,
  input  logic                        tick,
  uart_tx_buf_if.slave                in_if,
  output logic                        tx_bit,
  output logic                        tx_busy,
  output logic                        tx_done_tick,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int TCW = (NUM_TICKS > 1) ? $clog2(NUM_TICKS) : 1;
  localparam int BIW = (NBIT_DATA > 1) ? $clog2(NBIT_DATA) : 1;
  localparam logic [TCW-1:0] TICK_LAST = TCW'(NUM_TICKS - 1);
  localparam logic [BIW-1:0] BIT_LAST  = BIW'(NBIT_DATA - 1);

  uart_state_e          state_q, state_d;
  logic [TCW-1:0]       tick_cnt_q, tick_cnt_d;
  logic [BIW-1:0]       bit_idx_q, bit_idx_d;
  logic [NBIT_DATA-1:0] shift_q, shift_d;
  logic                 tx_bit_q, tx_bit_d;
  logic                 done_q, done_d;

  logic                 fifo_pop;
  logic [NBIT_DATA-1:0] fifo_dout;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 bit_end;

  uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (NBIT_DATA)
  ) u_fifo (
    .clk   (CLK),
    .reset (reset),
    .push  (in_if.data_valid),
    .pop   (fifo_pop),
    .din   (in_if.data_in),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign in_if.data_ready = !fifo_full;
  assign tx_bit           = tx_bit_q;
  assign tx_done_tick     = done_q;
  assign tx_busy          = (state_q != IDLE);

  // Last tick of the current bit period.
  assign bit_end = tick && (tick_cnt_q == TICK_LAST);

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    fifo_pop   = 1'b0;
    done_d     = 1'b0;
    tx_bit_d   = 1'b1;

    case (state_q)
      IDLE: begin
        tx_bit_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shift_d    = fifo_dout;
          tick_cnt_d = '0;
          state_d    = START;
        end
      end
      START: begin
        tx_bit_d = 1'b0;
        if (bit_end) begin
          tick_cnt_d = '0;
          bit_idx_d  = '0;
          state_d    = DATA;
        end else if (tick) begin
          tick_cnt_d = tick_cnt_q + 1'b1;
        end
      end
      DATA: begin
        tx_bit_d = shift_q[0];
        if (bit_end) begin
          tick_cnt_d = '0;
          shift_d    = shift_q >> 1;
          if (bit_idx_q == BIT_LAST) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else if (tick) begin
          tick_cnt_d = tick_cnt_q + 1'b1;
        end
      end
      STOP: begin
        tx_bit_d = 1'b1;
        if (bit_end) begin
          tick_cnt_d = '0;
          done_d     = 1'b1;
          state_d    = IDLE;
        end else if (tick) begin
          tick_cnt_d = tick_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state; the line level is registered from the current state so
  // it lags the state by one cycle uniformly for every bit.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_idx_q  <= '0;
      tx_bit_q   <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_idx_q  <= bit_idx_d;
      tx_bit_q   <= tx_bit_d;
      done_q     <= done_d;
    end
  end

  // Shift register is data only; it is always reloaded before use.
  always_ff @(posedge CLK) begin
    shift_q <= shift_d;
  end

endmodule

// File: tb/tb_uart_tx_buf.sv
module tb_uart_tx_buf;

  logic       CLK = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       tx_bit;
  logic       tx_busy;
  logic       tx_done_tick;
  logic [2:0] fifo_count;

  uart_tx_buf_if #(.NBIT_DATA(8)) bus ();

  uart_tx_buf #(
    .NBIT_DATA  (8),
    .NUM_TICKS  (16),
    .FIFO_DEPTH (4)
  ) dut (
    .CLK          (CLK),
    .reset        (reset),
    .tick         (tick),
    .in_if        (bus),
    .tx_bit       (tx_bit),
    .tx_busy      (tx_busy),
    .tx_done_tick (tx_done_tick),
    .fifo_count   (fifo_count)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_done_cyc = 0;
  int accept_cyc = 0;
  bit tick_en = 1'b1;
  int div = 0;

  // Reference model: bytes accepted and not yet seen on the line.
  logic [7:0] exp_q[$];

  // Line decoder state (tick-counted, so it tolerates tick stalls).
  bit         mon_active = 1'b0;
  int         mon_d = 0;
  logic [9:0] mon_frame = '0;
  logic [9:0] last_frame = '0;
  logic       prev_bit = 1'b1;

  typedef struct {
    logic [7:0] din;
    logic [9:0] frame;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Model: every accepted handshake is queued; reset flushes everything.
  always @(posedge CLK) begin
    if (!reset) begin
      exp_q.delete();
    end else if (bus.data_valid === 1'b1 && bus.data_ready === 1'b1) begin
      exp_q.push_back(bus.data_in);
    end
  end

  // Monitor + tick generator, both on the falling edge.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge CLK);
      cyc++;
      if (tx_done_tick === 1'b1) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
      if (reset !== 1'b1) begin
        mon_active = 1'b0;
      end else if (!mon_active) begin
        if (prev_bit === 1'b1 && tx_bit === 1'b0) begin
          mon_active = 1'b1;
          mon_d = tick ? 1 : 0;
          mon_frame = '0;
        end
      end else if (tick) begin
        mon_d++;
        if (mon_d == 8) mon_frame[0] = tx_bit;
        for (int k = 0; k < 8; k++) begin
          if (mon_d == 16 * k + 24) mon_frame[k+1] = tx_bit;
        end
        if (mon_d == 152) begin
          mon_frame[9] = tx_bit;
          last_frame = mon_frame;
          mon_active = 1'b0;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_unexpected: got %h, required no frame", mon_frame);
          end else begin
            e = exp_q.pop_front();
            check("frame_scoreboard", 32'(mon_frame), 32'({1'b1, e, 1'b0}));
          end
        end
      end
      prev_bit = tx_bit;
      tick = tick_en && (div == 3);
      div = (div + 1) % 4;
    end
  end

  task automatic push_byte(input logic [7:0] b, input bit hold);
    int n = 0;
    bus.data_in = b;
    bus.data_valid = 1'b1;
    while (bus.data_ready !== 1'b1 && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 3000) begin
      n_checks++;
      n_fail++;
      $display("FAIL push_timeout: got no ready, required ready within 3000 cycles");
    end
    accept_cyc = cyc;
    @(negedge CLK);
    if (!hold) bus.data_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while ((exp_q.size() != 0 || tx_busy !== 1'b0 || fifo_count !== 3'd0) && n < limit) begin
      @(negedge CLK);
      n++;
    end
    if (n >= limit) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_idle: got busy after %0d cycles, required idle", n);
    end
    repeat (3) @(negedge CLK);
  endtask

  initial begin
    vec_t vecs[4];
    int   d0, t_ch[$], busy_n, bad, n;
    logic pb;

    bus.data_in = '0;
    bus.data_valid = 1'b0;
    vecs[0] = '{8'hA5, 10'b1_1010_0101_0};
    vecs[1] = '{8'h01, 10'b1_0000_0001_0};
    vecs[2] = '{8'h80, 10'b1_1000_0000_0};
    vecs[3] = '{8'hFF, 10'b1_1111_1111_0};

    // Reset
    reset = 1'b0;
    repeat (3) @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    check("rst_tx_bit", 32'(tx_bit), 32'd1);
    check("rst_tx_busy", 32'(tx_busy), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_data_ready", 32'(bus.data_ready), 32'd1);
    repeat (20) @(negedge CLK);
    check("rst_no_done", done_cnt, 0);

    // Table of single frames
    for (int i = 0; i < 4; i++) begin
      d0 = done_cnt;
      push_byte(vecs[i].din, 1'b0);
      wait_idle(2000);
      check("vec_frame", 32'(last_frame), 32'(vecs[i].frame));
      check("vec_done_once", done_cnt - d0, 1);
    end

    // 0xA5 bit timing on the line
    d0 = done_cnt;
    push_byte(8'hA5, 1'b0);
    pb = 1'b1;
    busy_n = 0;
    t_ch.delete();
    for (int i = 0; i < 800; i++) begin
      @(negedge CLK);
      if (tx_busy === 1'b1) busy_n++;
      if (tx_bit !== pb) begin
        t_ch.push_back(i);
        pb = tx_bit;
      end
    end
    check("a5_edges", t_ch.size(), 8);
    if (t_ch.size() == 8) begin
      check_range("a5_start_len", t_ch[1] - t_ch[0], 61, 64);
      check("a5_b0_len", t_ch[2] - t_ch[1], 64);
      check("a5_b1_len", t_ch[3] - t_ch[2], 64);
      check("a5_b2_len", t_ch[4] - t_ch[3], 64);
      check("a5_b34_len", t_ch[5] - t_ch[4], 128);
      check("a5_b5_len", t_ch[6] - t_ch[5], 64);
      check("a5_b6_len", t_ch[7] - t_ch[6], 64);
    end
    check_range("a5_busy_len", busy_n, 637, 640);
    check("a5_done_once", done_cnt - d0, 1);
    wait_idle(2000);

    // Full FIFO with data_valid held high
    d0 = done_cnt;
    push_byte(8'h00, 1'b1);
    push_byte(8'hFF, 1'b1);
    push_byte(8'h55, 1'b1);
    push_byte(8'h81, 1'b1);
    push_byte(8'h3C, 1'b1);
    check("full_count", 32'(fifo_count), 32'd4);
    check("full_not_ready", 32'(bus.data_ready), 32'd0);
    push_byte(8'hC3, 1'b0);
    check_range("full_accept_after_done", accept_cyc - last_done_cyc, 0, 2);
    check("full_first_done_seen", done_cnt - d0, 1);
    wait_idle(6000);
    check("full_six_done", done_cnt - d0, 6);

    // Push while IDLE pops with count 1
    push_byte(8'h12, 1'b1);
    check("simul_count_a", 32'(fifo_count), 32'd1);
    push_byte(8'h34, 1'b0);
    check("simul_count_b", 32'(fifo_count), 32'd1);
    wait_idle(2000);

    // Reset during data bit 3 of 0x0F with another byte queued
    push_byte(8'h0F, 1'b1);
    push_byte(8'h77, 1'b0);
    n = 0;
    while (!(mon_active && mon_d >= 70) && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    check("midrst_reached_bit3", 32'(n < 3000), 32'd1);
    d0 = done_cnt;
    reset = 1'b0;
    @(negedge CLK);
    check("midrst_tx_bit", 32'(tx_bit), 32'd1);
    check("midrst_count", 32'(fifo_count), 32'd0);
    check("midrst_busy", 32'(tx_busy), 32'd0);
    reset = 1'b1;
    repeat (200) @(negedge CLK);
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_line_idle", 32'(tx_bit), 32'd1);
    push_byte(8'h42, 1'b0);
    wait_idle(2000);
    check("midrst_next_frame", 32'(last_frame), 32'(10'b1_0100_0010_0));

    // Tick stalled during the start bit
    push_byte(8'h3C, 1'b0);
    n = 0;
    while (!(tx_busy === 1'b1 && tx_bit === 1'b0) && n < 100) begin
      @(negedge CLK);
      n++;
    end
    tick_en = 1'b0;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLK);
      if (tx_bit !== 1'b0 || tx_busy !== 1'b1) bad++;
    end
    check("stall_held", bad, 0);
    tick_en = 1'b1;
    wait_idle(2000);
    check("stall_frame", 32'(last_frame), 32'(10'b1_0011_1100_0));

    // Randomized traffic against the scoreboard
    d0 = done_cnt;
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 40)) @(negedge CLK);
      push_byte(8'($urandom_range(0, 255)), 1'b0);
    end
    wait_idle(12000);
    check("rand_done_count", done_cnt - d0, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
